// File: rtl/imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// imm_extend_pipe
//
// Decode-stage immediate extension for the MIPS datapath. An IN_WIDTH-bit
// immediate is widened to OUT_WIDTH bits in one of four modes and then
// carried through STAGES register stages, each with a valid bit. The stage
// registers honour stall and flush so that the result stays aligned with the
// ID/EX pipeline registers it travels beside.
//
// Parameters
//   IN_WIDTH   immediate width (>= 2)
//   OUT_WIDTH  result width (>= IN_WIDTH + 2)
//   STAGES     number of register stages, 1..4
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears every stage
//   stall      holds every stage; the input is not captured
//   flush      clears every stage; wins over stall
//   in_valid   imm_in/mode carry a real immediate this cycle
//   mode       00 sign, 01 zero, 10 upper, 11 branch (sign-extend, << 2)
//   imm_in     raw immediate field
//   out_valid  valid bit of the last stage
//   imm_out    extended result of the last stage (0 whenever out_valid=0)
// ---------------------------------------------------------------------------
module imm_extend_pipe #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 32,
    parameter int STAGES    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [1:0]           mode,
    input  logic [IN_WIDTH-1:0]  imm_in,
    output logic                 out_valid,
    output logic [OUT_WIDTH-1:0] imm_out
);

    localparam int PadWidth = OUT_WIDTH - IN_WIDTH;

    localparam logic [1:0] ModeSign   = 2'b00;
    localparam logic [1:0] ModeZero   = 2'b01;
    localparam logic [1:0] ModeUpper  = 2'b10;
    localparam logic [1:0] ModeBranch = 2'b11;

    // Stage registers: index 0 is the stage fed by the input, index
    // STAGES-1 drives the outputs.
    logic [STAGES-1:0]                validQ;
    logic [STAGES-1:0]                validD;
    logic [STAGES-1:0][OUT_WIDTH-1:0] dataQ;
    logic [STAGES-1:0][OUT_WIDTH-1:0] dataD;

    logic [OUT_WIDTH-1:0] signExt;
    logic [OUT_WIDTH-1:0] extValue;

    // Extension function in front of stage 1. The width rule
    // OUT_WIDTH >= IN_WIDTH + 2 guarantees the branch shift never drops a
    // significant bit, and the upper concatenation is exactly OUT_WIDTH wide.
    always_comb begin
        signExt  = {{PadWidth{imm_in[IN_WIDTH-1]}}, imm_in};
        extValue = '0;
        case (mode)
            ModeSign:   extValue = signExt;
            ModeZero:   extValue = {{PadWidth{1'b0}}, imm_in};
            ModeUpper:  extValue = {imm_in, {PadWidth{1'b0}}};
            ModeBranch: extValue = {signExt[OUT_WIDTH-3:0], 2'b00};
            default:    extValue = '0;
        endcase
    end

    // Next-state for every stage. Flush clears regardless of stall; stall
    // simply keeps the defaults (hold). On advance, bubbles are forced to
    // carry zero data so a downstream consumer never sees stale values.
    always_comb begin
        validD = validQ;
        dataD  = dataQ;
        if (flush) begin
            validD = '0;
            dataD  = '0;
        end else if (!stall) begin
            validD[0] = in_valid;
            dataD[0]  = in_valid ? extValue : '0;
            for (int k = 1; k < STAGES; k++) begin
                validD[k] = validQ[k-1];
                dataD[k]  = dataQ[k-1];
            end
        end
    end

    // Stage register bank with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            validQ <= '0;
            dataQ  <= '0;
        end else begin
            validQ <= validD;
            dataQ  <= dataD;
        end
    end

    assign out_valid = validQ[STAGES-1];
    assign imm_out   = dataQ[STAGES-1];

endmodule

// File: tb/tb_imm_extend_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_extend_pipe
//
// Directed bench for imm_extend_pipe. Four instances (STAGES = 1..4) share
// the same input drive; each scenario checks the instance whose depth it
// targets. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_imm_extend_pipe;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        inValid;
    logic [1:0]  mode;
    logic [15:0] immIn;

    logic        outValid1, outValid2, outValid3, outValid4;
    logic [31:0] immOut1, immOut2, immOut3, immOut4;

    int total;
    int bad;

    localparam logic [1:0] MSign   = 2'b00;
    localparam logic [1:0] MZero   = 2'b01;
    localparam logic [1:0] MUpper  = 2'b10;
    localparam logic [1:0] MBranch = 2'b11;

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .STAGES(1)) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(inValid), .mode(mode), .imm_in(immIn),
        .out_valid(outValid1), .imm_out(immOut1)
    );

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .STAGES(2)) dut2 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(inValid), .mode(mode), .imm_in(immIn),
        .out_valid(outValid2), .imm_out(immOut2)
    );

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .STAGES(3)) dut3 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(inValid), .mode(mode), .imm_in(immIn),
        .out_valid(outValid3), .imm_out(immOut3)
    );

    imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32), .STAGES(4)) dut4 (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .in_valid(inValid), .mode(mode), .imm_in(immIn),
        .out_valid(outValid4), .imm_out(immOut4)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, take one rising edge, then settle #1 so the
    // outputs are sampled well away from the edge.
    task automatic applyStimulus(input logic rst, input logic stl, input logic fls,
                                 input logic vld, input logic [1:0] md,
                                 input logic [15:0] imm);
        reset   = rst;
        stall   = stl;
        flush   = fls;
        inValid = vld;
        mode    = md;
        immIn   = imm;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance idle cycles until every instance has drained.
    task automatic drain();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MSign, 16'h0000);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Reset state: start with junk on data inputs to show they are ignored.
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, MSign, 16'hFFFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, MSign, 16'hFFFF);
        checkOutput("rst_v1", {31'd0, outValid1}, 32'd0);
        checkOutput("rst_d1", immOut1, 32'h0000_0000);
        checkOutput("rst_v4", {31'd0, outValid4}, 32'd0);
        checkOutput("rst_d4", immOut4, 32'h0000_0000);

        // STAGES=1, every extension mode, one result per edge.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'hFFEC);
        checkOutput("s1_sign_neg_v", {31'd0, outValid1}, 32'd1);
        checkOutput("s1_sign_neg", immOut1, 32'hFFFF_FFEC);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h7FFF);
        checkOutput("s1_sign_pos", immOut1, 32'h0000_7FFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MZero, 16'h8000);
        checkOutput("s1_zero", immOut1, 32'h0000_8000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MUpper, 16'h1234);
        checkOutput("s1_upper", immOut1, 32'h1234_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MBranch, 16'hFFFF);
        checkOutput("s1_branch_neg", immOut1, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MBranch, 16'h7FFF);
        checkOutput("s1_branch_pos", immOut1, 32'h0001_FFFC);
        checkOutput("s1_branch_pos_v", {31'd0, outValid1}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MUpper, 16'hABCD);
        checkOutput("s1_bubble_v", {31'd0, outValid1}, 32'd0);
        checkOutput("s1_bubble_d", immOut1, 32'h0000_0000);
        drain();

        // STAGES=3 back-to-back stream: first result after the third edge.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h8000);
        checkOutput("s3_early_v", {31'd0, outValid3}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'hFFFF);
        checkOutput("s3_out0_v", {31'd0, outValid3}, 32'd1);
        checkOutput("s3_out0", immOut3, 32'h0000_0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MSign, 16'h0000);
        checkOutput("s3_out1_v", {31'd0, outValid3}, 32'd1);
        checkOutput("s3_out1", immOut3, 32'hFFFF_8000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MSign, 16'h0000);
        checkOutput("s3_out2", immOut3, 32'hFFFF_FFFF);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MSign, 16'h0000);
        checkOutput("s3_tail_v", {31'd0, outValid3}, 32'd0);
        checkOutput("s3_tail_d", immOut3, 32'h0000_0000);
        drain();

        // STAGES=2 stall for two cycles mid-stream; the input offered while
        // stalled (0x0099) is dropped, nothing else is lost or repeated.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h0011);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h0022);
        checkOutput("s2_a", immOut2, 32'h0000_0011);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, MSign, 16'h0099);
        checkOutput("s2_stall0", immOut2, 32'h0000_0011);
        checkOutput("s2_stall0_v", {31'd0, outValid2}, 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, MSign, 16'h0099);
        checkOutput("s2_stall1", immOut2, 32'h0000_0011);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h0033);
        checkOutput("s2_b", immOut2, 32'h0000_0022);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MSign, 16'h0000);
        checkOutput("s2_c", immOut2, 32'h0000_0033);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MSign, 16'h0000);
        checkOutput("s2_gap_v", {31'd0, outValid2}, 32'd0);
        checkOutput("s2_gap_d", immOut2, 32'h0000_0000);
        drain();

        // STAGES=2 stall and flush together: flush wins.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h0044);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h0055);
        checkOutput("s2f_pre", immOut2, 32'h0000_0044);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, MSign, 16'h0066);
        checkOutput("s2f_flush_v", {31'd0, outValid2}, 32'd0);
        checkOutput("s2f_flush_d", immOut2, 32'h0000_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MSign, 16'h0000);
        checkOutput("s2f_after1_v", {31'd0, outValid2}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MSign, 16'h0000);
        checkOutput("s2f_after2_v", {31'd0, outValid2}, 32'd0);
        drain();

        // STAGES=4 reset with three entries in flight, then a fresh entry
        // needs exactly four advances.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h0001);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h0002);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h0003);
        checkOutput("s4_inflight_v", {31'd0, outValid4}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, MSign, 16'h0004);
        checkOutput("s4_rst_v", {31'd0, outValid4}, 32'd0);
        checkOutput("s4_rst_d", immOut4, 32'h0000_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, MSign, 16'h0005);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MSign, 16'h0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MSign, 16'h0000);
        checkOutput("s4_adv3_v", {31'd0, outValid4}, 32'd0);
        checkOutput("s4_adv3_d", immOut4, 32'h0000_0000);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, MSign, 16'h0000);
        checkOutput("s4_adv4_v", {31'd0, outValid4}, 32'd1);
        checkOutput("s4_adv4_d", immOut4, 32'h0000_0005);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit for the decode stage of the MIPS datapath. It takes an IN_WIDTH-bit instruction immediate and produces an OUT_WIDTH-bit operand in one of four modes: sign-extend, zero-extend, upper-load, or branch offset (sign-extend then shift left by 2). The result travels through STAGES register stages with a valid bit. The pipeline supports stall and flush so it stays aligned with the ID/EX pipeline registers.

## Interface
- IN_WIDTH, 16, immediate width; must be ≥ 2
- OUT_WIDTH, 32, result width; must be ≥ IN_WIDTH + 2
- STAGES, 1, register stages between input and output; legal values 1..4
- clk  in  1  rising-edge clock, single clock domain
- reset  in  1  synchronous, active-high reset
- stall  in  1  when 1, every stage holds its contents
- flush  in  1  when 1, every stage's valid bit clears
- in_valid  in  1  input immediate is valid this cycle
- mode  in  2  00 sign, 01 zero, 10 upper, 11 branch
- imm_in  in  IN_WIDTH  raw immediate field
- out_valid  out  1  valid bit of the last stage
- imm_out  out  OUT_WIDTH  extended result of the last stage

## Operation
- Extension function E(mode, imm), computed combinationally in front of stage 1:
  - 00 sign: replicate imm[IN_WIDTH-1] into the upper OUT_WIDTH-IN_WIDTH bits.
  - 01 zero: upper bits are 0.
  - 10 upper: {imm, (OUT_WIDTH-IN_WIDTH) zeros}. When OUT_WIDTH < 2·IN_WIDTH, keep the low OUT_WIDTH bits of that concatenation.
  - 11 branch: sign-extended value shifted left by 2; bits [1:0] are 0. No bits are lost, by the width rule.
- Each stage k holds v[k] (1 bit) and d[k] (OUT_WIDTH bits). Stage 1 is loaded from the input; stage k is loaded from stage k-1.
- On every rising clk edge, the highest-priority matching case applies:
  1. reset=1: all v[k]=0 and all d[k]=0.
  2. flush=1: all v[k]=0 and all d[k]=0. This applies whatever stall is; flush wins over stall.
  3. stall=1: all stages hold. The input is not captured and is lost unless the source holds it.
  4. Otherwise: the pipeline advances.
     - v[1] = in_valid.
     - d[1] = E(mode, imm_in) if in_valid, else 0.
     - Stage k (k > 1): v[k] = v[k-1] and d[k] = d[k-1].
- Invalid (bubble) entries always carry data 0. A bubble never shows nonzero imm_out.
- mode and imm_in are sampled only when the pipeline advances with in_valid=1. At all other times their values do not matter.
- No internal state exists beyond the stage registers. There is no state machine and no counter.

## Timing
- Reset values: out_valid=0, imm_out=0. They take effect at the first rising edge with reset=1 and hold until the first edge with reset=0.
- Latency: an input accepted at edge N appears on out_valid/imm_out after edge N+STAGES-1 of advance. With no stalls, that means visible for the cycle following edge N+STAGES-1 (STAGES=1: visible right after edge N).
- Throughput: one immediate per non-stalled cycle.
- Each stall cycle adds exactly one cycle to the latency of every in-flight entry. Outputs are stable throughout a stall.
- Reset or flush mid-stream discards all in-flight entries. An input presented in the same cycle as reset or flush is also discarded.
- Outputs are pure register outputs; there is no combinational path from any input to imm_out or out_valid.

## Test plan
- STAGES=1, sign mode: imm_in=0xFFEC with in_valid=1 → next cycle imm_out=0xFFFFFFEC, out_valid=1. Then imm_in=0x7FFF → 0x00007FFF.
- STAGES=1, zero, upper and branch modes:
  - zero, 0x8000 → 0x00008000
  - upper, 0x1234 → 0x12340000
  - branch, 0xFFFF → 0xFFFFFFFC
  - branch, 0x7FFF → 0x0001FFFC
- STAGES=3, back-to-back stream of 0x0001, 0x8000, 0xFFFF in sign mode → outputs 0x00000001, 0xFFFF8000, 0xFFFFFFFF on consecutive cycles. The first output appears 3 cycles after the first input; there are no gaps.
- STAGES=2 with stall=1 held for 2 cycles mid-stream → outputs frozen for 2 cycles, then resume in order with no loss or duplication. in_valid=0 gaps → out_valid=0 with imm_out=0.
- STAGES=2: stall=1 and flush=1 in the same cycle → after that edge, out_valid=0 and imm_out=0. Two more edges with in_valid=0 → out_valid remains 0.
- STAGES=4: reset=1 asserted with 3 entries in flight → after that edge, out_valid=0 and imm_out=0. After reset drops, a new input 0x0005 (sign) → 0x00000005 after exactly 4 advances.
